fitness_kernel_hls_deadlock_report_unit: RTL
============================================

Name: fitness_kernel_hls_deadlock_report_unit

Overview:
- Downstream consumer of the per-instance deadlock monitors' `block` outputs.
- Filters transient stalls: a deadlock is confirmed only when any monitor stays blocked for THRESHOLD consecutive cycles.
- On confirmation it latches which monitors were blocked, raises a sticky flag and issues one valid/ready report to the host-side debug/status logic.
- Keeps a saturating count of stall duration while the deadlock persists.

Parameters:
- NUM_MONITORS, 4, number of monitor `block` inputs.
- IDX_W, 2, width of the reported index; must satisfy 2^IDX_W >= NUM_MONITORS.
- CNT_W, 16, width of the persistence and stall counters.
- THRESHOLD, 1024, consecutive blocked cycles required to confirm a deadlock; legal range 1..2^CNT_W-1.

Ports:
- clock  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- monitor_block  in  NUM_MONITORS  bit i = registered `block` output of monitor i.
- enable  in  1  detection enable; low forces return to IDLE from IDLE/SUSPECT.
- clear  in  1  one-cycle pulse; clears a latched deadlock and all state.
- deadlock  out  1  sticky flag; high from confirmation until clear/reset.
- report_valid  out  1  report handshake valid.
- report_ready  in  1  report handshake ready.
- report_mask  out  NUM_MONITORS  snapshot of monitor_block at the confirmation cycle.
- report_idx  out  IDX_W  index of the lowest set bit of report_mask.
- stall_cycles  out  CNT_W  saturating count of blocked cycles since SUSPECT entry.

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - state=IDLE.
  - deadlock, report_valid, report_mask, report_idx and stall_cycles all 0; persistence counter 0.
  - Reset overrides every other input.
- any_block = OR of monitor_block.
- Priority below reset: clear, then enable, then the state transitions.
  - clear=1 in any state: next state IDLE; all outputs and counters return to their reset values on the next edge. A pending report is dropped.
- IDLE:
  - If enable & any_block: go to SUSPECT; persistence counter=1; stall_cycles=1.
- SUSPECT:
  - If !enable or !any_block: go to IDLE; counters=0.
  - Otherwise the persistence counter and stall_cycles increment by 1.
  - When enable & any_block and the counter == THRESHOLD-1 (the THRESHOLD-th consecutive blocked cycle, counting SUSPECT entry as cycle 1): go to CONFIRMED. On that same edge:
    - deadlock=1, report_valid=1;
    - report_mask = monitor_block of that cycle;
    - report_idx = lowest set index of that mask.
  - The blocked mask may change between cycles; only any_block matters for persistence.
- THRESHOLD=1: IDLE goes directly to CONFIRMED on the first cycle with enable & any_block. SUSPECT is skipped and stall_cycles=1.
- CONFIRMED:
  - report_valid held high. report_mask and report_idx stay stable until the handshake.
  - On report_valid & report_ready: report_valid=0 next cycle; go to REPORTED.
- REPORTED:
  - deadlock stays 1. No further reports are issued until clear.
- stall_cycles:
  - In CONFIRMED and REPORTED it increments on each cycle with any_block=1 and holds on cycles with any_block=0.
  - It saturates at 2^CNT_W-1 and never wraps.
  - enable is ignored in CONFIRMED and REPORTED; the deadlock stays latched.
- Latency: deadlock and report_valid rise exactly THRESHOLD edges after the first sampled blocked cycle (with enable held).
- Monitor inputs are already registered. No extra input synchronisation; no combinational path from inputs to outputs.

Test Plan:
- THRESHOLD=8, enable=1, monitor_block=4'b0100 held -> deadlock and report_valid rise on the 8th edge after first assertion; report_mask=0100, report_idx=2, stall_cycles=8.
- monitor_block=0001 for 7 cycles, then 0000 for 1 cycle, then 0001 again -> no deadlock; counter restarts; deadlock rises 8 edges after re-assertion.
- Mask changes 0010 -> 1000 -> 1010 within the window, ending on 1010 at the confirmation cycle -> confirmed on the 8th cycle; report_mask=1010, report_idx=1.
- report_ready=0 for 5 cycles after confirmation, then 1 -> report_valid and mask stable for all 5 cycles; a single handshake; report_valid=0 afterwards; deadlock stays 1; stall_cycles keeps counting.
- CNT_W=4, THRESHOLD=8, block held 40 cycles -> stall_cycles saturates at 15.
- clear pulse in REPORTED with block still high -> all outputs 0 next cycle; state re-enters SUSPECT the following cycle. enable=0 during SUSPECT -> IDLE, counters 0. reset mid-SUSPECT -> all outputs 0.

Source files
------------

// File: rtl/fitness_kernel_hls_deadlock_report_unit.sv
// ---------------------------------------------------------------------------
// fitness_kernel_hls_deadlock_report_unit
//
// Purpose:
//   Consumes the registered `block` outputs of the per-instance deadlock
//   monitors. Transient stalls are filtered out: a deadlock is confirmed only
//   after some monitor has been blocked for THRESHOLD consecutive cycles.
//   On confirmation the blocked mask is latched, a sticky deadlock flag is
//   raised and a single valid/ready report is presented to the host side.
//   A saturating stall counter tracks how long the stall has lasted.
//
// Ports:
//   clock          in   rising-edge clock for all logic
//   reset          in   synchronous, active-high reset
//   monitor_block  in   [NUM_MONITORS] bit i = block output of monitor i
//   enable         in   detection enable (only honoured in IDLE/SUSPECT)
//   clear          in   one-cycle pulse returning everything to reset state
//   deadlock       out  sticky flag, set on confirmation
//   report_valid   out  report handshake valid
//   report_ready   in   report handshake ready
//   report_mask    out  [NUM_MONITORS] monitor_block at the confirmation cycle
//   report_idx     out  [IDX_W] lowest set index of report_mask
//   stall_cycles   out  [CNT_W] saturating count of blocked cycles
// ---------------------------------------------------------------------------
module fitness_kernel_hls_deadlock_report_unit #(
    parameter int NUM_MONITORS = 4,
    parameter int IDX_W        = 2,
    parameter int CNT_W        = 16,
    parameter int THRESHOLD    = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_MONITORS-1:0] monitor_block,
    input  logic                    enable,
    input  logic                    clear,
    output logic                    deadlock,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [NUM_MONITORS-1:0] report_mask,
    output logic [IDX_W-1:0]        report_idx,
    output logic [CNT_W-1:0]        stall_cycles
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SUSPECT   = 2'd1,
        CONFIRMED = 2'd2,
        REPORTED  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SUSPECT = CNT_W'(THRESHOLD - 1);

    state_t                  r_state,    w_state_next;
    logic [CNT_W-1:0]        r_persist,  w_persist_next;
    logic [CNT_W-1:0]        r_stall,    w_stall_next;
    logic                    r_deadlock, w_deadlock_next;
    logic                    r_valid,    w_valid_next;
    logic [NUM_MONITORS-1:0] r_mask,     w_mask_next;
    logic [IDX_W-1:0]        r_idx,      w_idx_next;

    logic                    w_any_block;
    logic [IDX_W-1:0]        w_low_idx;
    logic [CNT_W-1:0]        w_stall_inc;

    assign w_any_block = |monitor_block;

    // Stall counter sticks at all-ones instead of wrapping.
    assign w_stall_inc = (r_stall == {CNT_W{1'b1}}) ? r_stall : r_stall + 1'b1;

    // Lowest set index of the live mask; scanning downward lets the lowest
    // set bit win. Only used when the mask is known to be non-zero.
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
            if (monitor_block[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_persist  <= '0;
            r_stall    <= '0;
            r_deadlock <= 1'b0;
            r_valid    <= 1'b0;
            r_mask     <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_persist  <= w_persist_next;
            r_stall    <= w_stall_next;
            r_deadlock <= w_deadlock_next;
            r_valid    <= w_valid_next;
            r_mask     <= w_mask_next;
            r_idx      <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_persist_next  = r_persist;
        w_stall_next    = r_stall;
        w_deadlock_next = r_deadlock;
        w_valid_next    = r_valid;
        w_mask_next     = r_mask;
        w_idx_next      = r_idx;

        if (clear) begin
            // Drops any pending report along with all latched state.
            w_state_next    = IDLE;
            w_persist_next  = '0;
            w_stall_next    = '0;
            w_deadlock_next = 1'b0;
            w_valid_next    = 1'b0;
            w_mask_next     = '0;
            w_idx_next      = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && w_any_block) begin
                        w_persist_next = CNT_W'(1);
                        w_stall_next   = CNT_W'(1);
                        if (THRESHOLD == 1) begin
                            // First blocked cycle already meets the threshold.
                            w_state_next    = CONFIRMED;
                            w_deadlock_next = 1'b1;
                            w_valid_next    = 1'b1;
                            w_mask_next     = monitor_block;
                            w_idx_next      = w_low_idx;
                        end else begin
                            w_state_next = SUSPECT;
                        end
                    end
                end

                SUSPECT: begin
                    if (!enable || !w_any_block) begin
                        w_state_next   = IDLE;
                        w_persist_next = '0;
                        w_stall_next   = '0;
                    end else begin
                        w_persist_next = r_persist + 1'b1;
                        w_stall_next   = w_stall_inc;
                        // Counter holds the number of blocked cycles already
                        // seen, so THRESHOLD-1 means this is the final one.
                        if (r_persist == LAST_SUSPECT) begin
                            w_state_next    = CONFIRMED;
                            w_deadlock_next = 1'b1;
                            w_valid_next    = 1'b1;
                            w_mask_next     = monitor_block;
                            w_idx_next      = w_low_idx;
                        end
                    end
                end

                CONFIRMED: begin
                    if (w_any_block) begin
                        w_stall_next = w_stall_inc;
                    end
                    if (r_valid && report_ready) begin
                        w_valid_next = 1'b0;
                        w_state_next = REPORTED;
                    end
                end

                REPORTED: begin
                    if (w_any_block) begin
                        w_stall_next = w_stall_inc;
                    end
                end

                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign deadlock     = r_deadlock;
    assign report_valid = r_valid;
    assign report_mask  = r_mask;
    assign report_idx   = r_idx;
    assign stall_cycles = r_stall;

endmodule
